// File: rtl/leaf_spine_uplink_if.sv
`default_nettype none
// ============================================================================
// leaf_spine_uplink_if : leaf-side TX/RX and spine-link signal bundle
// Revision: 1.0
// ============================================================================
interface leaf_spine_uplink_if #(
  parameter int NUM_SPINES = 4,
  parameter int DWIDTH     = 16
);
  logic [DWIDTH-1:0]            local_tx_data;
  logic                         local_tx_valid;
  logic                         local_tx_ready;
  logic [NUM_SPINES*DWIDTH-1:0] up_data;
  logic [NUM_SPINES-1:0]        up_valid;
  logic [NUM_SPINES-1:0]        spine_full;
  logic [NUM_SPINES*DWIDTH-1:0] down_data;
  logic [NUM_SPINES-1:0]        down_valid;
  logic [NUM_SPINES-1:0]        down_full;
  logic [DWIDTH-1:0]            local_rx_data;
  logic                         local_rx_valid;
  logic                         local_rx_ready;
  logic [7:0]                   rx_drop_count;
  logic [7:0]                   rx_misroute_count;

  modport master (
    output local_tx_data, local_tx_valid, spine_full, down_data, down_valid, local_rx_ready,
    input  local_tx_ready, up_data, up_valid, down_full, local_rx_data, local_rx_valid,
           rx_drop_count, rx_misroute_count
  );

  modport slave (
    input  local_tx_data, local_tx_valid, spine_full, down_data, down_valid, local_rx_ready,
    output local_tx_ready, up_data, up_valid, down_full, local_rx_data, local_rx_valid,
           rx_drop_count, rx_misroute_count
  );
endinterface
`default_nettype wire

// File: rtl/leaf_spine_uplink.sv
`default_nettype none
// ============================================================================
// leaf_spine_uplink : round-robin TX spray onto spine links, RX merge to leaf
// Revision: 1.0
// ============================================================================
module leaf_spine_uplink #(
  parameter logic [3:0] GROUP_ID   = 4'b1000,
  parameter int         LEAF_ID    = 0,
  parameter int         NUM_SPINES = 4,
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  leaf_spine_uplink_if.slave bus
);
  localparam int               c_AW    = $clog2(FIFO_DEPTH);
  localparam int               c_SW    = (NUM_SPINES > 2) ? 2 : 1;
  localparam logic [1:0]       c_LEAF  = LEAF_ID[1:0];
  localparam logic [c_AW+1:0]  c_DEPTH = (c_AW+2)'(FIFO_DEPTH);

  function automatic logic [c_SW-1:0] f_wrap(input int v);
    return c_SW'(v % NUM_SPINES);
  endfunction

  function automatic logic [7:0] f_sat_add(input logic [7:0] cnt, input logic [NUM_SPINES-1:0] inc);
    int s;
    s = int'(cnt) + $countones(inc);
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  // ---------------------------------------------------------------- TX path
  logic [DWIDTH-1:0]            r_tx_mem [FIFO_DEPTH];
  logic [c_AW:0]                r_tx_wr, r_tx_rd;
  logic                         r_stage_v;
  logic [DWIDTH-1:0]            r_stage;
  logic [c_SW-1:0]              r_tx_rr;
  logic [NUM_SPINES-1:0]        r_up_valid;
  logic [NUM_SPINES*DWIDTH-1:0] r_up_data;

  logic [c_AW:0]   w_tx_used;
  logic [c_AW+1:0] w_tx_count;
  logic            w_tx_full, w_tx_mem_empty, w_tx_push, w_tx_found, w_tx_go, w_stage_load;
  logic [c_SW-1:0] w_tx_sel;

  // The output stage register counts toward occupancy so ready reflects all held flits.
  assign w_tx_used      = r_tx_wr - r_tx_rd;
  assign w_tx_count     = {1'b0, w_tx_used} + {{(c_AW+1){1'b0}}, r_stage_v};
  assign w_tx_full      = (w_tx_count >= c_DEPTH);
  assign w_tx_mem_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_push      = bus.local_tx_valid && bus.local_tx_ready;

  always_comb begin
    w_tx_found = 1'b0;
    w_tx_sel   = '0;
    for (int i = 0; i < NUM_SPINES; i++) begin
      if (!w_tx_found && !bus.spine_full[f_wrap(int'(r_tx_rr) + i)]) begin
        w_tx_found = 1'b1;
        w_tx_sel   = f_wrap(int'(r_tx_rr) + i);
      end
    end
  end

  assign w_tx_go      = r_stage_v && w_tx_found;
  assign w_stage_load = !w_tx_mem_empty && (!r_stage_v || w_tx_go);

  always_ff @(posedge clk) begin
    if (w_tx_push && !reset) begin
      r_tx_mem[r_tx_wr[c_AW-1:0]] <= bus.local_tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_stage_v  <= 1'b0;
      r_stage    <= '0;
      r_tx_rr    <= '0;
      r_up_valid <= '0;
      r_up_data  <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_wr <= r_tx_wr + 1'b1;
      end
      if (w_stage_load) begin
        r_stage   <= r_tx_mem[r_tx_rd[c_AW-1:0]];
        r_tx_rd   <= r_tx_rd + 1'b1;
        r_stage_v <= 1'b1;
      end else if (w_tx_go) begin
        r_stage_v <= 1'b0;
      end
      r_up_valid <= '0;
      r_up_data  <= '0;
      if (w_tx_go) begin
        r_up_valid[w_tx_sel]                   <= 1'b1;
        r_up_data[w_tx_sel*DWIDTH +: DWIDTH]   <= r_stage;
        r_tx_rr                                <= f_wrap(int'(w_tx_sel) + 1);
      end
    end
  end

  assign bus.local_tx_ready = !w_tx_full && !reset;
  assign bus.up_valid       = r_up_valid;
  assign bus.up_data        = r_up_data;

  // ---------------------------------------------------------------- RX path
  logic [DWIDTH-1:0]     r_hold [NUM_SPINES];
  logic [NUM_SPINES-1:0] r_hold_v;
  logic [c_SW-1:0]       r_rx_rr;
  logic [DWIDTH-1:0]     r_rx_mem [FIFO_DEPTH];
  logic [c_AW:0]         r_rx_wr, r_rx_rd;
  logic [7:0]            r_drop_cnt, r_mis_cnt;

  logic                  w_rx_full, w_rx_empty, w_rx_pop, w_rx_found, w_drain;
  logic [c_SW-1:0]       w_rx_sel;
  logic [NUM_SPINES-1:0] w_mis, w_load, w_drop, w_drained;

  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[c_AW] != r_rx_rd[c_AW]) &&
                      (r_rx_wr[c_AW-1:0] == r_rx_rd[c_AW-1:0]);
  assign w_rx_pop   = !w_rx_empty && bus.local_rx_ready;

  always_comb begin
    w_rx_found = 1'b0;
    w_rx_sel   = '0;
    for (int i = 0; i < NUM_SPINES; i++) begin
      if (!w_rx_found && r_hold_v[f_wrap(int'(r_rx_rr) + i)]) begin
        w_rx_found = 1'b1;
        w_rx_sel   = f_wrap(int'(r_rx_rr) + i);
      end
    end
  end

  assign w_drain = w_rx_found && !w_rx_full;

  generate
    for (genvar k = 0; k < NUM_SPINES; k++) begin : g_link
      logic [DWIDTH-1:0] w_flit;
      logic              w_hit;
      assign w_flit       = bus.down_data[k*DWIDTH +: DWIDTH];
      assign w_hit        = (w_flit[15:12] == GROUP_ID) && (w_flit[11:10] == c_LEAF);
      assign w_drained[k] = w_drain && (w_rx_sel == c_SW'(k));
      // A register emptied by the merge this cycle can take a new flit in the same edge.
      assign w_mis[k]     = bus.down_valid[k] && !w_hit;
      assign w_load[k]    = bus.down_valid[k] && w_hit && (!r_hold_v[k] || w_drained[k]);
      assign w_drop[k]    = bus.down_valid[k] && w_hit && !w_load[k];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_drain && !reset) begin
      r_rx_mem[r_rx_wr[c_AW-1:0]] <= r_hold[w_rx_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_v   <= '0;
      r_rx_rr    <= '0;
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_drop_cnt <= '0;
      r_mis_cnt  <= '0;
      for (int k = 0; k < NUM_SPINES; k++) begin
        r_hold[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SPINES; k++) begin
        if (w_load[k]) begin
          r_hold[k]   <= bus.down_data[k*DWIDTH +: DWIDTH];
          r_hold_v[k] <= 1'b1;
        end else if (w_drained[k]) begin
          r_hold_v[k] <= 1'b0;
        end
      end
      if (w_drain) begin
        r_rx_wr <= r_rx_wr + 1'b1;
        r_rx_rr <= f_wrap(int'(w_rx_sel) + 1);
      end
      if (w_rx_pop) begin
        r_rx_rd <= r_rx_rd + 1'b1;
      end
      r_drop_cnt <= f_sat_add(r_drop_cnt, w_drop);
      r_mis_cnt  <= f_sat_add(r_mis_cnt, w_mis);
    end
  end

  assign bus.down_full         = r_hold_v;
  assign bus.local_rx_data     = r_rx_mem[r_rx_rd[c_AW-1:0]];
  assign bus.local_rx_valid    = !w_rx_empty;
  assign bus.rx_drop_count     = r_drop_cnt;
  assign bus.rx_misroute_count = r_mis_cnt;
endmodule
`default_nettype wire

// File: tb/tb_leaf_spine_uplink.sv
`default_nettype none
// ============================================================================
// tb_leaf_spine_uplink : directed + randomized checks of leaf_spine_uplink
// Revision: 1.0
// ============================================================================
module tb_leaf_spine_uplink;
  localparam int NS = 4;

  logic clk;
  logic reset;

  leaf_spine_uplink_if #(.NUM_SPINES(NS), .DWIDTH(16)) ifc();

  leaf_spine_uplink #(
    .GROUP_ID(4'b1000), .LEAF_ID(0), .NUM_SPINES(NS), .DWIDTH(16), .FIFO_DEPTH(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] tx_exp_q [$];
  int          pulse_q  [$];
  logic [15:0] rx_got_q [$];
  logic [15:0] rx_exp_q [NS][$];
  int          m_tx_rr = 0;
  logic [3:0]  sf_prev = '0;
  int          mon_ek, mon_got;
  logic [15:0] mon_flit;

  int          acc, n_good, m_mis, cnt2, lk;
  int          last_tx [NS];
  logic [3:0]  dv;
  logic [63:0] dd;
  logic [15:0] fl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input int n, input logic [15:0] base, output int accepted);
    accepted = 0;
    for (int c = 0; c < n; c++) begin
      ifc.local_tx_valid = 1'b1;
      ifc.local_tx_data  = base + 16'(c);
      @(negedge clk);
      if (ifc.local_tx_ready) begin
        tx_exp_q.push_back(ifc.local_tx_data);
        accepted++;
      end
      tick();
    end
    ifc.local_tx_valid = 1'b0;
  endtask

  // Spine pushes: the chosen link must be the first non-full one from the model pointer,
  // as seen in the cycle before the pulse, and carry the oldest unsent flit.
  always @(negedge clk) begin
    if (!reset) begin
      if (ifc.up_valid != '0) begin
        mon_ek = -1;
        for (int i = 0; i < NS; i++)
          if (mon_ek < 0 && !sf_prev[(m_tx_rr + i) % NS]) mon_ek = (m_tx_rr + i) % NS;
        mon_got = -1;
        for (int i = 0; i < NS; i++)
          if (mon_got < 0 && ifc.up_valid[i]) mon_got = i;
        pulse_q.push_back(mon_got);
        check("tx_spine", 64'(ifc.up_valid), (mon_ek < 0) ? 64'd0 : (64'd1 << mon_ek));
        check("tx_flit_pending", 64'(tx_exp_q.size() > 0), 64'd1);
        if (tx_exp_q.size() > 0 && mon_ek >= 0) begin
          mon_flit = tx_exp_q.pop_front();
          check("tx_up_data", ifc.up_data, 64'(mon_flit) << (16 * mon_ek));
          m_tx_rr = (mon_ek + 1) % NS;
        end
      end
      if (ifc.local_rx_valid && ifc.local_rx_ready) rx_got_q.push_back(ifc.local_rx_data);
    end
    sf_prev = ifc.spine_full;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ifc.local_tx_data  = '0;
    ifc.local_tx_valid = 1'b0;
    ifc.spine_full     = '0;
    ifc.down_data      = '0;
    ifc.down_valid     = '0;
    ifc.local_rx_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_up_valid", 64'(ifc.up_valid), 64'd0);
    check("rst_up_data", ifc.up_data, 64'd0);
    check("rst_down_full", 64'(ifc.down_full), 64'd0);
    check("rst_rx_valid", 64'(ifc.local_rx_valid), 64'd0);
    check("rst_tx_ready", 64'(ifc.local_tx_ready), 64'd1);
    check("rst_drop", 64'(ifc.rx_drop_count), 64'd0);
    check("rst_mis", 64'(ifc.rx_misroute_count), 64'd0);

    // Four flits, all spines free: one-hot 0,1,2,3, first pulse two edges after accept.
    pulse_q.delete();
    for (int c = 0; c < 9; c++) begin
      ifc.local_tx_valid = (c < 4);
      ifc.local_tx_data  = 16'h8001 + 16'(c);
      @(negedge clk);
      if (c < 4 && ifc.local_tx_ready) tx_exp_q.push_back(ifc.local_tx_data);
      check("t1_up_valid_timing", 64'(ifc.up_valid), (c >= 3 && c <= 6) ? (64'd1 << (c - 3)) : 64'd0);
      tick();
    end
    ifc.local_tx_valid = 1'b0;
    check("t1_pulses", 64'(pulse_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < pulse_q.size(); i++) check("t1_order", 64'(pulse_q[i]), 64'(i));

    // Spines 0 and 2 full: alternate 1,3.
    pulse_q.delete();
    ifc.spine_full = 4'b0101;
    send_tx(4, 16'h8005, acc);
    repeat (6) tick();
    check("t2_pulses", 64'(pulse_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < pulse_q.size(); i++) check("t2_order", 64'(pulse_q[i]), (i % 2 == 0) ? 64'd1 : 64'd3);

    // All full: eight fill the TX buffer, then only spine 2 opens.
    pulse_q.delete();
    ifc.spine_full = 4'hF;
    send_tx(12, 16'h8100, acc);
    check("t2_fill_accepts", 64'(acc), 64'd8);
    check("t2_fill_ready", 64'(ifc.local_tx_ready), 64'd0);
    check("t2_fill_no_push", 64'(pulse_q.size()), 64'd0);
    ifc.spine_full = 4'b1011;
    repeat (14) tick();
    check("t2_drain_pulses", 64'(pulse_q.size()), 64'd8);
    cnt2 = 0;
    foreach (pulse_q[i]) if (pulse_q[i] == 2) cnt2++;
    check("t2_drain_spine2", 64'(cnt2), 64'd8);
    check("t2_tx_empty", 64'(tx_exp_q.size()), 64'd0);
    ifc.spine_full = 4'h0;

    // Four simultaneous down flits merge in link order.
    ifc.local_rx_ready = 1'b1;
    rx_got_q.delete();
    ifc.down_data  = {16'h8044, 16'h8033, 16'h8022, 16'h8011};
    ifc.down_valid = 4'hF;
    tick();
    ifc.down_valid = 4'h0;
    @(negedge clk);
    check("t3_down_full", 64'(ifc.down_full), 64'hF);
    check("t3_rx_valid_early", 64'(ifc.local_rx_valid), 64'd0);
    tick();
    @(negedge clk);
    check("t3_rx_valid", 64'(ifc.local_rx_valid), 64'd1);
    check("t3_rx_head", 64'(ifc.local_rx_data), 64'h8011);
    repeat (8) tick();
    check("t3_count", 64'(rx_got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < rx_got_q.size(); i++) check("t3_order", 64'(rx_got_q[i]), 64'h8011 + 64'(i) * 64'h11);
    check("t3_drop", 64'(ifc.rx_drop_count), 64'd0);
    check("t3_mis", 64'(ifc.rx_misroute_count), 64'd0);

    // Wrong group on link 2.
    rx_got_q.delete();
    ifc.down_data  = {16'h0, 16'h9001, 16'h0, 16'h0};
    ifc.down_valid = 4'b0100;
    tick();
    ifc.down_valid = 4'h0;
    repeat (4) tick();
    check("t4_mis", 64'(ifc.rx_misroute_count), 64'd1);
    check("t4_not_delivered", 64'(rx_got_q.size()), 64'd0);
    check("t4_down_full", 64'(ifc.down_full), 64'd0);

    // Overrun on link 0 with the leaf stalled.
    ifc.local_rx_ready = 1'b0;
    rx_got_q.delete();
    for (int c = 0; c < 11; c++) begin
      ifc.down_data  = {48'h0, 16'h8000 | 16'(c)};
      ifc.down_valid = 4'b0001;
      tick();
    end
    ifc.down_valid = 4'h0;
    @(negedge clk);
    check("t5_held", 64'(ifc.down_full), 64'd1);
    check("t5_drop2", 64'(ifc.rx_drop_count), 64'd2);
    check("t5_rx_valid", 64'(ifc.local_rx_valid), 64'd1);
    tick();
    for (int c = 0; c < 300; c++) begin
      ifc.down_data  = {48'h0, 16'h8000 | 16'(c & 16'h3FF)};
      ifc.down_valid = 4'b0001;
      tick();
    end
    ifc.down_valid = 4'h0;
    tick();
    check("t5_drop_sat", 64'(ifc.rx_drop_count), 64'd255);
    check("t5_mis_hold", 64'(ifc.rx_misroute_count), 64'd1);
    ifc.local_rx_ready = 1'b1;
    repeat (15) tick();
    check("t5_delivered", 64'(rx_got_q.size()), 64'd9);
    for (int i = 0; i < 9 && i < rx_got_q.size(); i++) check("t5_order", 64'(rx_got_q[i]), 64'h8000 + 64'(i));

    // Reset with traffic buffered on both sides.
    ifc.spine_full = 4'hF;
    send_tx(3, 16'h8200, acc);
    ifc.local_rx_ready = 1'b0;
    ifc.down_data  = {16'h0, 16'h8302, 16'h8301, 16'h0};
    ifc.down_valid = 4'b0110;
    tick();
    ifc.down_valid = 4'h0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tx_exp_q.delete();
    pulse_q.delete();
    rx_got_q.delete();
    m_tx_rr = 0;
    #1;
    check("t6_up_valid", 64'(ifc.up_valid), 64'd0);
    check("t6_rx_valid", 64'(ifc.local_rx_valid), 64'd0);
    check("t6_down_full", 64'(ifc.down_full), 64'd0);
    check("t6_drop", 64'(ifc.rx_drop_count), 64'd0);
    check("t6_mis", 64'(ifc.rx_misroute_count), 64'd0);
    check("t6_tx_ready", 64'(ifc.local_tx_ready), 64'd1);
    ifc.spine_full     = 4'h0;
    ifc.local_rx_ready = 1'b1;
    repeat (6) tick();
    check("t6_tx_discarded", 64'(pulse_q.size()), 64'd0);
    check("t6_rx_discarded", 64'(rx_got_q.size()), 64'd0);

    // Random TX traffic under random backpressure.
    for (int c = 0; c < 80; c++) begin
      ifc.local_tx_valid = 1'($urandom_range(0, 1));
      ifc.local_tx_data  = 16'($urandom);
      ifc.spine_full     = 4'($urandom);
      @(negedge clk);
      if (ifc.local_tx_valid && ifc.local_tx_ready) tx_exp_q.push_back(ifc.local_tx_data);
      tick();
    end
    ifc.local_tx_valid = 1'b0;
    ifc.spine_full     = 4'h0;
    for (int c = 0; c < 40 && tx_exp_q.size() > 0; c++) tick();
    check("rand_tx_drained", 64'(tx_exp_q.size()), 64'd0);

    // Random RX traffic; each link idles >=4 cycles between flits so nothing overruns.
    rx_got_q.delete();
    n_good = 0;
    m_mis  = 0;
    for (int k = 0; k < NS; k++) last_tx[k] = -10;
    for (int c = 0; c < 80; c++) begin
      dv = '0;
      dd = '0;
      for (int k = 0; k < NS; k++) begin
        if (c - last_tx[k] >= 4 && $urandom_range(0, 1) == 1) begin
          last_tx[k] = c;
          dv[k] = 1'b1;
          case ($urandom_range(0, 4))
            0: begin
              fl = {4'h8 ^ 4'($urandom_range(1, 15)), 12'($urandom)};
              m_mis++;
            end
            1: begin
              fl = {4'h8, 2'($urandom_range(1, 3)), 10'($urandom)};
              m_mis++;
            end
            default: begin
              fl = {4'h8, 2'b00, 2'(k), 8'($urandom)};
              rx_exp_q[k].push_back(fl);
              n_good++;
            end
          endcase
          dd[k*16 +: 16] = fl;
        end
      end
      ifc.down_data  = dd;
      ifc.down_valid = dv;
      tick();
    end
    ifc.down_valid = 4'h0;
    repeat (12) tick();
    check("rand_rx_count", 64'(rx_got_q.size()), 64'(n_good));
    while (rx_got_q.size() > 0) begin
      fl = rx_got_q.pop_front();
      lk = int'(fl[9:8]);
      check("rand_rx_expected", 64'(rx_exp_q[lk].size() > 0), 64'd1);
      if (rx_exp_q[lk].size() > 0) check("rand_rx_data", 64'(fl), 64'(rx_exp_q[lk].pop_front()));
    end
    check("rand_rx_mis", 64'(ifc.rx_misroute_count), 64'(m_mis));
    check("rand_rx_drop", 64'(ifc.rx_drop_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
